regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Controller that shares one 32x32 register file between two requesters, A and B.
- Each requester gets single-cycle write access and read access with registered data.
- Arbitration is round-robin.
- Runs a clear sequence that writes zero to every register after reset and on request.
- Sits between the register file and its clients. Owns the register file's write enable, address and write data.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width
NUM_REGS, 32, number of registers cleared; must equal 2**ADDR_WIDTH

Ports:
clk  input  1  clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
clr_req  input  1  request a full clear; sampled in IDLE only
busy  output  1  high while clearing
a_req  input  1  requester A access request
a_we  input  1  A: 1=write, 0=read
a_addr  input  ADDR_WIDTH  A register address
a_wdata  input  DATA_WIDTH  A write data
a_gnt  output  1  A request accepted this cycle (combinational)
a_rvalid  output  1  A read data valid (one-cycle pulse)
a_rdata  output  DATA_WIDTH  A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A for requester B
rf_we  output  1  register file write enable
rf_addr  output  ADDR_WIDTH  register file address, shared by read and write
rf_wdata  output  DATA_WIDTH  register file write data
rf_rdata  input  DATA_WIDTH  register file combinational read of rf_addr

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. No other clocks or resets.
- Reset values:
  - state=CLEAR, clear counter=0, priority=A.
  - a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, busy=1.
  - rf_we forced to 0 while rst=1.
- States:
  - CLEAR:
    - rf_we=1, rf_addr=counter, rf_wdata=0, busy=1. No grants.
    - Counter increments each cycle.
    - When counter==NUM_REGS-1, go to IDLE and reset the counter to 0.
    - A clear lasts exactly NUM_REGS cycles. clr_req is ignored during it.
  - IDLE:
    - busy=0.
    - If clr_req=1: no grant this cycle; go to CLEAR next cycle. Clear takes priority over requests.
    - Otherwise arbitrate:
      - Single request: grant it.
      - Both requesting: grant the requester holding priority.
      - Grant is combinational in the same cycle as the request; a transaction completes when req&gnt.
      - Priority moves to the other requester after each grant.
- Granted access:
  - rf_addr = granted address.
  - Write: rf_we=1, rf_wdata = granted wdata.
  - Read: rf_we=0. rf_rdata is captured into x_rdata at the clock edge. x_rvalid=1 for exactly the next cycle.
  - Read latency is 1 cycle from grant to rvalid.
  - x_rdata holds its value until the next read by the same requester.
- Ungranted requester: holds req and its fields stable until granted. The controller does not check this.
- No grant and not clearing: rf_we=0, rf_addr=0, rf_wdata=0.
- Boundary cases:
  - Read granted in the cycle before clr_req takes effect: its rvalid is still delivered during the first CLEAR cycle.
  - rst mid-clear: sequence restarts at address 0 and runs the full NUM_REGS cycles.
  - rst in the cycle after a read grant: rvalid is suppressed.
  - Same-address write by A then read by B on consecutive grants: B reads the new value.

Optional Feature:
- Macro: REGFILE_ACCESS_CTRL_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are granted normally, but rf_we stays 0.
  - Reads of address 0 return 0 with normal rvalid timing, regardless of rf_rdata.
  - The clear sequence is unchanged.
- Undefined: address 0 behaves as an ordinary register.

Test Plan:
- Release rst -> busy=1 for 32 cycles; rf_we=1, rf_wdata=0, rf_addr steps 0..31; busy=0 on cycle 33; no grants while busy.
- After clear, A writes 0xDEADBEEF to addr 5, then A reads addr 5 -> a_gnt on both cycles; a_rvalid=1 one cycle after the read grant with a_rdata=0xDEADBEEF; b_rvalid stays 0.
- A and B both request reads continuously at addrs 3 and 4 -> grants alternate A,B,A,B starting with A; each rvalid one cycle after its own grant.
- Registers preloaded with nonzero data; pulse clr_req in IDLE while both request -> no grant that cycle; 32 clear cycles; then a read of addr 7 returns 0.
- Assert rst for one cycle when the clear counter is 10 -> next clear starts at addr 0 and lasts the full 32 cycles.
- With REGFILE_ACCESS_CTRL_ZERO_REG_EN defined: write 0x1234 to addr 0 -> gnt=1, rf_we=0. Read addr 0 with rf_rdata forced to 0xFFFFFFFF -> rdata=0.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_access_ctrl
//  Purpose  : Round-robin sharing of one register file between requesters A
//             and B, with a zero-fill clear sequence after reset/on request.
//             Optional macro REGFILE_ACCESS_CTRL_ZERO_REG_EN hardwires reg 0
//             to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [DATA_WIDTH-1:0] rf_rdata
);

`ifdef REGFILE_ACCESS_CTRL_ZERO_REG_EN
    localparam bit c_ZERO_REG = 1'b1;
`else
    localparam bit c_ZERO_REG = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
    logic                    r_prio;        // 0: A holds priority, 1: B
    logic                    r_a_rvalid;
    logic                    r_b_rvalid;
    logic [DATA_WIDTH-1:0]   r_a_rdata;
    logic [DATA_WIDTH-1:0]   r_b_rdata;
    logic                    w_a_zero;
    logic                    w_b_zero;

    assign w_a_zero = c_ZERO_REG && (a_addr == '0);
    assign w_b_zero = c_ZERO_REG && (b_addr == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        rf_we       = 1'b0;
        rf_addr     = '0;
        rf_wdata    = '0;
        case (r_state)
            ST_CLEAR: begin
                rf_we   = 1'b1;
                rf_addr = r_cnt;
                if (r_cnt == c_LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end else if (a_req && (!b_req || !r_prio)) begin
                    a_gnt    = 1'b1;
                    rf_addr  = a_addr;
                    rf_we    = a_we && !w_a_zero;
                    rf_wdata = a_wdata;
                end else if (b_req) begin
                    b_gnt    = 1'b1;
                    rf_addr  = b_addr;
                    rf_we    = b_we && !w_b_zero;
                    rf_wdata = b_wdata;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
        // Reset overrides everything that could touch the register file.
        if (rst) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
            rf_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_cnt      <= '0;
            r_prio     <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_a_rvalid <= a_gnt && !a_we;
            r_b_rvalid <= b_gnt && !b_we;
            if (a_gnt) begin
                r_prio <= 1'b1;
            end else if (b_gnt) begin
                r_prio <= 1'b0;
            end
            if (a_gnt && !a_we) begin
                r_a_rdata <= w_a_zero ? '0 : rf_rdata;
            end
            if (b_gnt && !b_we) begin
                r_b_rdata <= w_b_zero ? '0 : rf_rdata;
            end
        end
    end

    assign busy     = rst || (r_state == ST_CLEAR);
    assign a_rvalid = r_a_rvalid && !rst;
    assign b_rvalid = r_b_rvalid && !rst;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_access_ctrl
//  Purpose  : Directed plus randomized bench for regfile_access_ctrl against a
//             transaction-level reference model and a behavioural regfile.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
`ifdef REGFILE_ACCESS_CTRL_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, clr_req, busy;
    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata, rf_rdata;
    logic          force_ff;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // Behavioural register file with combinational read.
    logic [DW-1:0] rf_mem [NR];
    always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    assign rf_rdata = force_ff ? {DW{1'b1}} : rf_mem[rf_addr];

    // Reference model state.
    int            n_checks = 0;
    int            n_errors = 0;
    int            m_clear_left = 0;
    bit            m_prio = 1'b0;
    bit            m_known = 1'b0;
    bit            m_ga, m_gb, m_a_rv, m_b_rv;
    logic [DW-1:0] m_a_rd, m_b_rd;
    logic [DW-1:0] m_mem [NR];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_zero_reg(input logic [AW-1:0] ad);
        return ZR && (ad == '0);
    endfunction

    // Called at a falling edge with inputs already applied; checks this
    // cycle's outputs, advances the model across the rising edge.
    task automatic step();
        bit            e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        #1;
        m_ga = 1'b0;
        m_gb = 1'b0;
        if (!rst && m_clear_left == 0 && !clr_req) begin
            if (a_req && b_req) begin
                if (m_prio == 1'b0) m_ga = 1'b1; else m_gb = 1'b1;
            end else if (a_req) m_ga = 1'b1;
            else if (b_req) m_gb = 1'b1;
        end
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (!rst && m_clear_left > 0) begin
            e_we = 1'b1; e_addr = AW'(NR - m_clear_left);
        end else if (m_ga) begin
            e_we = a_we && !is_zero_reg(a_addr); e_addr = a_addr; e_wd = a_wdata;
        end else if (m_gb) begin
            e_we = b_we && !is_zero_reg(b_addr); e_addr = b_addr; e_wd = b_wdata;
        end
        check("busy", busy, rst || m_clear_left > 0);
        check("a_gnt", a_gnt, m_ga);
        check("b_gnt", b_gnt, m_gb);
        check("rf_we", rf_we, e_we);
        check("a_rvalid", a_rvalid, !rst && m_a_rv);
        check("b_rvalid", b_rvalid, !rst && m_b_rv);
        if (!rst) begin
            check("rf_addr", rf_addr, e_addr);
            check("rf_wdata", rf_wdata, e_wd);
            if (m_known) begin
                check("a_rdata", a_rdata, m_a_rd);
                check("b_rdata", b_rdata, m_b_rd);
            end
        end
        if (rst) begin
            m_clear_left = NR; m_prio = 1'b0; m_known = 1'b1;
            m_a_rv = 1'b0; m_b_rv = 1'b0; m_a_rd = '0; m_b_rd = '0;
        end else begin
            m_a_rv = 1'b0;
            m_b_rv = 1'b0;
            if (m_clear_left > 0) begin
                m_mem[NR - m_clear_left] = '0;
                m_clear_left--;
            end else if (clr_req) begin
                m_clear_left = NR;
            end else if (m_ga) begin
                m_prio = 1'b1;
                if (a_we) begin
                    if (!is_zero_reg(a_addr)) m_mem[a_addr] = a_wdata;
                end else begin
                    m_a_rv = 1'b1;
                    m_a_rd = is_zero_reg(a_addr) ? '0 : m_mem[a_addr];
                end
            end else if (m_gb) begin
                m_prio = 1'b0;
                if (b_we) begin
                    if (!is_zero_reg(b_addr)) m_mem[b_addr] = b_wdata;
                end else begin
                    m_b_rv = 1'b1;
                    m_b_rd = is_zero_reg(b_addr) ? '0 : m_mem[b_addr];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0; force_ff = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        @(negedge clk);
        steps(2);
        rst = 1'b0;

        // Power-up clear: 32 busy cycles stepping addresses 0..31.
        steps(NR);
        check("busy_after_clear", busy, 1'b0);

        // A writes then reads address 5.
        a_req = 1'b1; a_we = 1'b1; a_addr = 5; a_wdata = 32'hDEADBEEF;
        step();
        a_we = 1'b0;
        step();
        a_req = 1'b0;
        step();
        check("a_rdata_beef", a_rdata, 32'hDEADBEEF);

        // Hand priority back to A, then contend with back-to-back reads.
        b_req = 1'b1; b_we = 1'b0; b_addr = 4;
        step();
        a_req = 1'b1; a_we = 1'b0; a_addr = 3;
        steps(8);
        a_req = 1'b0; b_req = 1'b0;
        step();

        // Write by A then read of the same address by B.
        a_req = 1'b1; a_we = 1'b1; a_addr = 9; a_wdata = 32'hCAFE0009;
        step();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9;
        step();
        b_req = 1'b0;
        step();
        check("b_raw_rdata", b_rdata, 32'hCAFE0009);

        // Preload, then clear while both request; addr 7 must read back 0.
        a_req = 1'b1; a_we = 1'b1; a_addr = 7; a_wdata = 32'h77777777;
        step();
        a_we = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        steps(NR);
        b_req = 1'b0;
        step();
        a_req = 1'b0;
        step();
        check("a_rdata_cleared", a_rdata, '0);

        // Reset when the clear counter is at 10.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        steps(10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(NR);
        check("busy_after_reclear", busy, 1'b0);

        if (ZR) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = 0; a_wdata = 32'h1234;
            step();
            a_we = 1'b0; force_ff = 1'b1;
            step();
            force_ff = 1'b0; a_req = 1'b0;
            step();
            check("zero_reg_rdata", a_rdata, '0);
        end

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(399) == 0);
            clr_req = ($urandom_range(49) == 0);
            if (!a_req && $urandom_range(2) != 0) begin
                a_req = 1'b1; a_we = $urandom_range(1) == 1;
                a_addr = $urandom_range(1) == 1 ? AW'($urandom_range(3)) : AW'($urandom);
                a_wdata = $urandom;
            end
            if (!b_req && $urandom_range(2) != 0) begin
                b_req = 1'b1; b_we = $urandom_range(1) == 1;
                b_addr = $urandom_range(1) == 1 ? AW'($urandom_range(3)) : AW'($urandom);
                b_wdata = $urandom;
            end
            step();
            if (m_ga) a_req = 1'b0;
            if (m_gb) b_req = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
